// File: rtl/ghr_checkpoint.sv
// Speculative global-history register with a per-branch checkpoint FIFO.
// The fetch-side history is shifted on prediction and repaired from a checkpoint on a mispredict.
module ghr_checkpoint #(
  parameter int unsigned k     = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         StallF,
  input  logic                         BranchF,
  input  logic                         PredDirF,
  input  logic                         StallE,
  input  logic                         BranchE,
  input  logic                         PCSrcE,
  input  logic                         TrapFlush,
  output logic [k-1:0]                 GHRSpecF,
  output logic [k-1:0]                 GHRArch,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic                         Full,
  output logic                         MispredE,
  output logic                         ResolveEmptyE
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [k-1:0]    spec_q, spec_d;
  logic [k-1:0]    arch_q, arch_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic [k-1:0] ckpt_q [DEPTH];
  logic         pred_q [DEPTH];

  logic push_req, resolve, empty, mismatch;
  logic resolve_empty, mispred, pop, push_ok;
  logic [k-1:0] head_ckpt;
  logic         head_pred;

  assign push_req  = BranchF & ~StallF;
  assign resolve   = BranchE & ~StallE;
  assign empty     = (count_q == '0);
  assign head_ckpt = ckpt_q[head_q];
  assign head_pred = pred_q[head_q];
  assign mismatch  = (PCSrcE != head_pred);

  assign resolve_empty = resolve & empty & ~TrapFlush;
  assign mispred       = resolve & ~empty & ~TrapFlush & mismatch;
  assign pop           = resolve & ~empty & ~TrapFlush & ~mismatch;
  // A push may use the slot freed by a same-cycle correct pop, even when full.
  assign push_ok       = push_req & (~Full | pop) & ~TrapFlush & ~mispred & ~resolve_empty;

  assign GHRSpecF      = spec_q;
  assign GHRArch       = arch_q;
  assign Count         = count_q;
  assign Full          = (count_q == CntW'(DEPTH));
  assign MispredE      = mispred;
  assign ResolveEmptyE = resolve_empty;

  always_comb begin
    spec_d  = spec_q;
    arch_d  = arch_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (TrapFlush) begin
      spec_d  = arch_q;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (resolve) begin
        arch_d = {PCSrcE, arch_q[k-1:1]};
      end
      if (resolve_empty) begin
        spec_d = {PCSrcE, arch_q[k-1:1]};
      end else if (mispred) begin
        spec_d  = {PCSrcE, head_ckpt[k-1:1]};
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push_ok) begin
          spec_d = {PredDirF, spec_q[k-1:1]};
          tail_d = tail_q + PtrW'(1);
        end
        if (pop) begin
          head_d = head_q + PtrW'(1);
        end
        if (push_ok && !pop) begin
          count_d = count_q + CntW'(1);
        end else if (!push_ok && pop) begin
          count_d = count_q - CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spec_q  <= '0;
      arch_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      spec_q  <= spec_d;
      arch_q  <= arch_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Checkpoint storage needs no reset; entries are only read while Count is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      ckpt_q[tail_q] <= spec_q;
      pred_q[tail_q] <= PredDirF;
    end
  end

endmodule

// File: tb/tb_ghr_checkpoint.sv
// Directed bench for ghr_checkpoint with k=4, DEPTH=4 and hand-computed expectations.
module tb_ghr_checkpoint;

  logic       clk = 1'b0;
  logic       reset, StallF, BranchF, PredDirF, StallE, BranchE, PCSrcE, TrapFlush;
  logic [3:0] GHRSpecF, GHRArch;
  logic [2:0] Count;
  logic       Full, MispredE, ResolveEmptyE;

  int checks = 0;
  int errors = 0;

  ghr_checkpoint #(.k(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .BranchF(BranchF), .PredDirF(PredDirF),
    .StallE(StallE), .BranchE(BranchE), .PCSrcE(PCSrcE), .TrapFlush(TrapFlush),
    .GHRSpecF(GHRSpecF), .GHRArch(GHRArch), .Count(Count), .Full(Full),
    .MispredE(MispredE), .ResolveEmptyE(ResolveEmptyE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    BranchF = 0; PredDirF = 0; BranchE = 0; PCSrcE = 0; TrapFlush = 0;
    StallF = 0; StallE = 0;
  endtask

  // Apply the current inputs for one clock edge, then sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic dir);
    idle(); BranchF = 1; PredDirF = dir;
    tick();
  endtask

  task automatic resolve(input logic dir);
    idle(); BranchE = 1; PCSrcE = dir;
    tick();
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
    // 1. reset state
    check("rst_spec", GHRSpecF, 4'b0000);
    check("rst_arch", GHRArch, 4'b0000);
    check("rst_count", Count, 0);
    check("rst_full", Full, 0);
    check("rst_mispred", MispredE, 0);
    check("rst_empty", ResolveEmptyE, 0);

    // 2. three pushes
    push(1); check("p1_spec", GHRSpecF, 4'b1000);
    push(0); check("p2_spec", GHRSpecF, 4'b0100);
    push(1); check("p3_spec", GHRSpecF, 4'b1010);
    check("p3_count", Count, 3);

    // 3. correct resolve of head (pred 1)
    idle(); BranchE = 1; PCSrcE = 1; #1;
    check("r1_mispred", MispredE, 0);
    tick();
    check("r1_arch", GHRArch, 4'b1000);
    check("r1_count", Count, 2);
    check("r1_spec", GHRSpecF, 4'b1010);

    // 4. mispredict (pred 0, ckpt 1000) with a wrong-path push
    idle(); BranchE = 1; PCSrcE = 1; BranchF = 1; PredDirF = 1; #1;
    check("m_mispred", MispredE, 1);
    tick();
    check("m_spec", GHRSpecF, 4'b1100);
    check("m_arch", GHRArch, 4'b1100);
    check("m_count", Count, 0);
    idle(); #1;
    check("m_mispred_clr", MispredE, 0);

    // 5. fill to Full, dropped push, push+pop while Full
    push(1); push(1); push(0); push(1);
    check("f_spec", GHRSpecF, 4'b1011);
    check("f_count", Count, 4);
    check("f_full", Full, 1);
    push(0);
    check("drop_count", Count, 4);
    check("drop_spec", GHRSpecF, 4'b1011);
    idle(); BranchF = 1; PredDirF = 0; BranchE = 1; PCSrcE = 1; #1;
    check("pp_mispred", MispredE, 0);
    tick();
    check("pp_count", Count, 4);
    check("pp_spec", GHRSpecF, 4'b0101);
    check("pp_arch", GHRArch, 4'b1110);
    check("pp_full", Full, 1);

    // Mid-operation reset with a full FIFO and a pending push
    idle(); BranchF = 1; PredDirF = 1; reset = 1;
    tick();
    reset = 0;
    check("mr_count", Count, 0);
    check("mr_spec", GHRSpecF, 4'b0000);
    check("mr_arch", GHRArch, 4'b0000);

    // Build Count=2, GHRArch=0110
    push(1); push(1); push(0); push(1);
    resolve(1); resolve(1);
    idle(); BranchE = 1; PCSrcE = 0; BranchF = 1; PredDirF = 0;
    tick();
    check("b_arch", GHRArch, 4'b0110);
    check("b_count", Count, 2);
    check("b_spec", GHRSpecF, 4'b0101);

    // 6. TrapFlush overrides same-cycle resolve and push
    idle(); TrapFlush = 1; BranchE = 1; PCSrcE = 1; BranchF = 1; PredDirF = 1; #1;
    check("t_mispred", MispredE, 0);
    tick();
    check("t_count", Count, 0);
    check("t_spec", GHRSpecF, 4'b0110);
    check("t_arch", GHRArch, 4'b0110);

    // Resolve on empty
    idle(); BranchE = 1; PCSrcE = 1; BranchF = 1; PredDirF = 0; #1;
    check("e_flag", ResolveEmptyE, 1);
    check("e_mispred", MispredE, 0);
    tick();
    check("e_arch", GHRArch, 4'b1011);
    check("e_spec", GHRSpecF, 4'b1011);
    check("e_count", Count, 0);
    idle(); #1;
    check("e_flag_clr", ResolveEmptyE, 0);

    // Stalls block push and resolve
    idle(); BranchF = 1; PredDirF = 0; StallF = 1;
    tick();
    check("sf_count", Count, 0);
    push(0);
    check("n_spec", GHRSpecF, 4'b0101);
    idle(); BranchE = 1; PCSrcE = 1; StallE = 1; #1;
    check("se_mispred", MispredE, 0);
    tick();
    check("se_count", Count, 1);
    check("se_arch", GHRArch, 4'b1011);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
